// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES-128 round controller.
// The key-schedule round constant steps by xtime (multiply by x in GF(2^8)).
package aes_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int         NUM_ROUNDS_DEF = 10;
   localparam logic [7:0] RCON_INIT      = 8'h01;
   localparam logic [7:0] AES_XTIME_POLY = 8'h1b;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the AES key schedule: reloads 8'h01 on block
// load and advances by xtime after each non-final round.
module aes_rcon_gen
   import aes_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_init,
   input  logic       i_advance,
   output logic [7:0] o_rcon
);

   logic [7:0] r_rcon;

   // Init wins over advance so a fresh block always starts from round 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rcon <= RCON_INIT;
      end else if (i_init) begin
         r_rcon <= RCON_INIT;
      end else if (i_advance) begin
         r_rcon <= xtime(r_rcon);
      end
   end

   assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the one-round-per-clock AES-128 datapath: accepts a block,
// pulses the load, steps round_idx/rcon, then holds the result until taken.
module aes_round_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int ROUND_W    = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               load_en,
   output logic               round_en,
   output logic [ROUND_W-1:0] round_idx,
   output logic               final_round,
   output logic [7:0]         rcon,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output state_t             dbg_state
);

   localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS);

   state_t             r_state;
   logic [ROUND_W-1:0] r_round_idx;
   logic               r_load_en;
   logic               r_round_en;
   logic               r_final_round;
   logic               r_busy;
   logic               r_out_valid;

   state_t             w_state_nxt;
   logic [ROUND_W-1:0] w_round_idx_nxt;
   logic               w_hs;
   logic               w_rcon_init;
   logic               w_rcon_adv;

   // Handshakes: a transfer happens on a rising clk edge where valid & ready
   // are both high. in_ready never depends on in_valid; out_valid, once high,
   // stays high with stable datapath contents until out_ready is seen.
   assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_hs     = in_valid && in_ready;

   always_comb begin
      w_state_nxt     = r_state;
      w_round_idx_nxt = r_round_idx;
      w_rcon_init     = 1'b0;
      w_rcon_adv      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_state_nxt     = LOAD;
               w_round_idx_nxt = '0;
            end
         end
         LOAD: begin
            w_state_nxt     = ROUND;
            w_round_idx_nxt = ROUND_W'(1);
            w_rcon_init     = 1'b1;
         end
         ROUND: begin
            if (r_round_idx == LAST_IDX) begin
               w_state_nxt = DONE;
            end else begin
               w_round_idx_nxt = r_round_idx + ROUND_W'(1);
               w_rcon_adv      = 1'b1;
            end
         end
         DONE: begin
            // Consumer taking the result while a new request waits goes
            // straight to LOAD, so back-to-back blocks see no idle bubble.
            if (out_ready) begin
               if (in_valid) begin
                  w_state_nxt     = LOAD;
                  w_round_idx_nxt = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_round_idx   <= '0;
         r_load_en     <= 1'b0;
         r_round_en    <= 1'b0;
         r_final_round <= 1'b0;
         r_busy        <= 1'b0;
         r_out_valid   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_round_idx   <= w_round_idx_nxt;
         r_load_en     <= (w_state_nxt == LOAD);
         r_round_en    <= (w_state_nxt == ROUND);
         r_final_round <= (w_state_nxt == ROUND) && (w_round_idx_nxt == LAST_IDX);
         r_busy        <= (w_state_nxt == LOAD) || (w_state_nxt == ROUND);
         r_out_valid   <= (w_state_nxt == DONE);
      end
   end

   aes_rcon_gen u_rcon_gen (
      .clk       (clk),
      .rst       (rst),
      .i_init    (w_rcon_init),
      .i_advance (w_rcon_adv),
      .o_rcon    (rcon)
   );

   assign load_en     = r_load_en;
   assign round_en    = r_round_en;
   assign round_idx   = r_round_idx;
   assign final_round = r_final_round;
   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign dbg_state   = r_state;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencing controller for the iterative AES-128 encryption datapath: one round per clock on the shared 128-bit state register.
- Accepts a block request through a valid/ready handshake and pulses the state/key load.
- Steps the round counter and supplies the key-expansion round constant.
- Holds the result valid until the downstream consumer accepts it.
- Sits between the host/testbench interface and the round datapath plus key-expansion logic; owns no data bits itself.

Parameters:
- NUM_ROUNDS, 10, rounds per block (10 for AES-128); final round omits MixColumns.
- ROUND_W, 4, width of round_idx; must satisfy 2^ROUND_W > NUM_ROUNDS.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester has plaintext+key ready on the datapath inputs.
- in_ready  output  1  controller accepts a block this cycle.
- load_en  output  1  one-cycle pulse: datapath loads plaintext XOR key, key regs load key.
- round_en  output  1  datapath applies one round this cycle.
- round_idx  output  ROUND_W  current round number, 0 at load, 1..NUM_ROUNDS in rounds.
- final_round  output  1  high when round_idx == NUM_ROUNDS; datapath bypasses MixColumns.
- rcon  output  8  round constant for the key-schedule step of the current round.
- busy  output  1  high in LOAD and ROUND states.
- out_valid  output  1  ciphertext on datapath state register is valid.
- out_ready  input  1  consumer accepts ciphertext.

Behaviour:
- States: IDLE, LOAD, ROUND, DONE.
- Reset (async, any state, mid-block included):
  - state=IDLE, round_idx=0, rcon=8'h01.
  - load_en=0, round_en=0, final_round=0, busy=0, out_valid=0.
  - An in-flight block is discarded; no out_valid is produced for it.
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational.
- Handshake fires on in_valid & in_ready.
- IDLE: on handshake -> LOAD; otherwise stay.
- LOAD (exactly 1 cycle):
  - load_en=1, round_idx=0.
  - rcon register reinitialised to 8'h01 for round 1.
  - Next state: ROUND, round_idx=1.
- ROUND:
  - round_en=1, busy=1, rcon valid for round_idx.
  - If round_idx < NUM_ROUNDS: round_idx+=1, rcon<=xtime(rcon); xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - If round_idx == NUM_ROUNDS: final_round=1, next state DONE.
- DONE:
  - out_valid=1, round_en=0, busy=0.
  - out_ready=0: hold DONE, no outputs change.
  - out_ready=1 & in_valid=0: -> IDLE.
  - out_ready=1 & in_valid=1: back-to-back; -> LOAD directly, so no IDLE bubble.
- Latency: handshake in cycle 0 -> load_en in cycle 1 -> rounds in cycles 2..NUM_ROUNDS+1 -> out_valid first high in cycle NUM_ROUNDS+2 (12 for defaults).
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- in_valid while busy is ignored; in_ready=0, so the request stays pending.
- round_idx never exceeds NUM_ROUNDS; no wrap.
- All outputs are registered except in_ready.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state enum (IDLE, LOAD, ROUND, DONE);
  - RCON_INIT = 8'h01;
  - AES_XTIME_POLY = 8'h1b;
  - default NUM_ROUNDS.
- One natural sub-module, aes_rcon_gen: 8-bit register with init (on LOAD) and advance (on non-final round) controls and an xtime next-state function.

Test Plan:
- Single block: in_valid=1 for 1 cycle from IDLE -> load_en pulse in cycle 1; round_idx 1..10 in cycles 2..11; final_round only in cycle 11; out_valid high from cycle 12.
- rcon check: log rcon on each round_en cycle -> exactly 01,02,04,08,10,20,40,80,1b,36.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, in_ready=0, round_idx stays 10. out_ready=1 with in_valid=0 -> IDLE next cycle.
- Back-to-back: in_valid held 1 and out_ready=1 -> second load_en in the cycle after first out_valid. Blocks complete every 12 cycles with no IDLE cycle.
- Reset mid-operation: assert rst asynchronously at round_idx=5 -> all outputs at reset values immediately. After release plus a new handshake, the next run restarts at round 1 with rcon=01 and produces exactly one out_valid.
- Ignored request: in_valid pulsed in cycle 6 of a run -> in_ready=0, no second load, round sequence unaffected.
